// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI burst responder and its beat-address helper.
package axi_pkg;

  localparam int unsigned BYTES_LOG = 3;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StWresp
  } resp_state_e;

endpackage

// File: rtl/axi_burst_responder_if.sv
// AXI4 subordinate-side channel bundle (AW/W/B/AR/R) with master and slave views.
interface axi_burst_responder_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic [2:0]            s_axi_awsize;
  logic [1:0]            s_axi_awburst;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

endinterface

// File: rtl/axi_beat_addr.sv
// Combinational AXI beat-address generator for FIXED/INCR/WRAP bursts.
module axi_beat_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] start_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  input  logic [7:0]            beat_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] mask;
  logic                  wrap_ok;

  always_comb begin
    incr    = start_i + (ADDR_WIDTH'(beat_i) << size_i);
    mask    = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    wrap_ok = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
    // Illegal WRAP lengths and the reserved encoding fall back to INCR.
    addr_o  = incr;
    if (burst_i == BurstFixed) begin
      addr_o = start_i;
    end else if (burst_i == BurstWrap && wrap_ok) begin
      addr_o = (start_i & ~mask) | (incr & mask);
    end
  end

endmodule

// File: rtl/axi_burst_responder.sv
// AXI4 burst responder backed by a word-addressed memory, one transaction at a time.
// Optional DECERR on out-of-range addresses when AXI_RESP_DECERR_EN is defined.
module axi_burst_responder
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8 << BYTES_LOG,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned MEM_WORDS_LOG = 12
) (
  input logic                 clk,
  input logic                 reset,
  axi_burst_responder_if.slave axi
);

  localparam int unsigned BytesLog = $clog2(DATA_WIDTH / 8);
  localparam int unsigned MemWords = 1 << MEM_WORDS_LOG;

  resp_state_e           st_q, st_d;
  logic [7:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [MemWords];

  logic [ADDR_WIDTH-1:0]    sel_addr, beat_addr;
  logic [7:0]               sel_len, sel_beat;
  logic [2:0]               sel_size;
  logic [1:0]               sel_burst;
  logic [MEM_WORDS_LOG-1:0] idx;
  logic                     last, rd_load, mem_we, oob;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     unused_lo;

  // In IDLE the generator looks at the incoming AR so the first word is fetched at the handshake.
  always_comb begin
    sel_addr  = addr_q;
    sel_len   = len_q;
    sel_size  = size_q;
    sel_burst = burst_q;
    sel_beat  = beat_q;
    if (st_q == StIdle) begin
      sel_addr  = axi.s_axi_araddr;
      sel_len   = axi.s_axi_arlen;
      sel_size  = axi.s_axi_arsize;
      sel_burst = axi.s_axi_arburst;
      sel_beat  = '0;
    end else if (st_q == StRd && axi.s_axi_rready) begin
      sel_beat  = beat_q + 8'd1;
    end
  end

  axi_beat_addr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_beat_addr (
    .start_i(sel_addr),
    .len_i  (sel_len),
    .size_i (sel_size),
    .burst_i(sel_burst),
    .beat_i (sel_beat),
    .addr_o (beat_addr)
  );

  assign idx       = beat_addr[BytesLog +: MEM_WORDS_LOG];
  assign unused_lo = ^beat_addr[BytesLog-1:0];
  assign last      = (beat_q == len_q);

`ifdef AXI_RESP_DECERR_EN
  logic       dec_q, dec_d;
  logic [1:0] rresp_q;
  assign oob     = |(beat_addr >> (BytesLog + MEM_WORDS_LOG));
  assign rd_word = oob ? '0 : mem_q[idx];
  assign axi.s_axi_rresp = rresp_q;
  assign axi.s_axi_bresp = dec_q ? RespDecerr : (err_q ? RespSlverr : RespOkay);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_q   <= 1'b0;
      rresp_q <= RespOkay;
    end else begin
      dec_q <= dec_d;
      if (rd_load) rresp_q <= oob ? RespDecerr : RespOkay;
    end
  end
`else
  logic unused_hi;
  assign oob       = 1'b0;
  assign unused_hi = ^beat_addr[ADDR_WIDTH-1:BytesLog+MEM_WORDS_LOG];
  assign rd_word   = mem_q[idx];
  assign axi.s_axi_rresp = RespOkay;
  assign axi.s_axi_bresp = err_q ? RespSlverr : RespOkay;
`endif

  always_comb begin
    st_d    = st_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    rd_load = 1'b0;
    mem_we  = 1'b0;
`ifdef AXI_RESP_DECERR_EN
    dec_d   = dec_q;
`endif
    unique case (st_q)
      StIdle: begin
        if (axi.s_axi_arvalid) begin
          addr_d  = axi.s_axi_araddr;
          len_d   = axi.s_axi_arlen;
          size_d  = axi.s_axi_arsize;
          burst_d = axi.s_axi_arburst;
          beat_d  = '0;
          rd_load = 1'b1;
          st_d    = StRd;
        end else if (axi.s_axi_awvalid) begin
          addr_d  = axi.s_axi_awaddr;
          len_d   = axi.s_axi_awlen;
          size_d  = axi.s_axi_awsize;
          burst_d = axi.s_axi_awburst;
          beat_d  = '0;
          st_d    = StWr;
        end
      end
      StRd: begin
        if (axi.s_axi_rready) begin
          if (last) begin
            st_d = StIdle;
          end else begin
            beat_d  = beat_q + 8'd1;
            rd_load = 1'b1;
          end
        end
      end
      StWr: begin
        if (axi.s_axi_wvalid) begin
          mem_we = !oob;
`ifdef AXI_RESP_DECERR_EN
          if (oob) dec_d = 1'b1;
`endif
          if (axi.s_axi_wlast != last) err_d = 1'b1;
          if (last) st_d = StWresp;
          else      beat_d = beat_q + 8'd1;
        end
      end
      StWresp: begin
        if (axi.s_axi_bready) begin
          err_d = 1'b0;
`ifdef AXI_RESP_DECERR_EN
          dec_d = 1'b0;
`endif
          st_d  = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= StIdle;
      beat_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      if (rd_load) rdata_q <= rd_word;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= axi.s_axi_wdata;
  end

  assign axi.s_axi_arready = (st_q == StIdle);
  assign axi.s_axi_awready = (st_q == StIdle) && !axi.s_axi_arvalid && !reset;
  assign axi.s_axi_wready  = (st_q == StWr);
  assign axi.s_axi_bvalid  = (st_q == StWresp);
  assign axi.s_axi_rvalid  = (st_q == StRd);
  assign axi.s_axi_rlast   = (st_q == StRd) && last;
  assign axi.s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_burst_responder.sv
// Directed self-checking bench for axi_burst_responder.
module tb_axi_burst_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_aw_blocked = 1'b0;
  logic [63:0] exp_w [16];
  logic [1:0]  resp;

  axi_burst_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  axi_burst_responder #(
    .DATA_WIDTH   (64),
    .ADDR_WIDTH   (64),
    .MEM_WORDS_LOG(12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .axi  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic axi_write(input string tag, input logic [63:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [63:0] d0, input int lastbeat,
                           output logic [1:0] r);
    int n;
    bus.s_axi_awaddr  = a;
    bus.s_axi_awlen   = len;
    bus.s_axi_awsize  = 3'd3;
    bus.s_axi_awburst = burst;
    bus.s_axi_awvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.s_axi_awready && n < 200) begin tick(); n++; end
    check({tag, "_aw_wait"}, 64'(n < 200), 64'd1);
    tick();
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.s_axi_wdata  = d0 + 64'(i);
      bus.s_axi_wlast  = (i == lastbeat);
      bus.s_axi_wvalid = 1'b1;
      #1;
      n = 0;
      while (!bus.s_axi_wready && n < 200) begin tick(); n++; end
      if (n >= 200) check({tag, "_w_wait"}, 64'd0, 64'd1);
      tick();
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
    bus.s_axi_bready = 1'b1;
    #1;
    n = 0;
    while (!bus.s_axi_bvalid && n < 200) begin tick(); n++; end
    check({tag, "_b_wait"}, 64'(n < 200), 64'd1);
    r = bus.s_axi_bresp;
    tick();
    bus.s_axi_bready = 1'b0;
  endtask

  // rready follows 1,0,0,1 repeating when stall is set.
  task automatic axi_read(input string tag, input logic [63:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall);
    int n, beat, cyc;
    bit rr;
    bus.s_axi_araddr  = a;
    bus.s_axi_arlen   = len;
    bus.s_axi_arsize  = 3'd3;
    bus.s_axi_arburst = burst;
    bus.s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.s_axi_arready && n < 200) begin tick(); n++; end
    check({tag, "_ar_wait"}, 64'(n < 200), 64'd1);
    tick();
    bus.s_axi_arvalid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 200) begin
      rr = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      bus.s_axi_rready = rr;
      #1;
      check($sformatf("%s_rvalid%0d", tag, cyc), 64'(bus.s_axi_rvalid), 64'd1);
      check($sformatf("%s_rdata%0d", tag, beat), bus.s_axi_rdata, exp_w[beat]);
      if (chk_aw_blocked) check({tag, "_awready_blk"}, 64'(bus.s_axi_awready), 64'd0);
      if (rr) begin
        check($sformatf("%s_rlast%0d", tag, beat), 64'(bus.s_axi_rlast), 64'(beat == int'(len)));
        check($sformatf("%s_rresp%0d", tag, beat), 64'(bus.s_axi_rresp), 64'd0);
        beat++;
      end
      cyc++;
      tick();
    end
    bus.s_axi_rready = 1'b0;
    check({tag, "_beats"}, 64'(beat), 64'(int'(len) + 1));
    if (!stall) check({tag, "_cycles"}, 64'(cyc), 64'(int'(len) + 1));
    check({tag, "_arready_after"}, 64'(bus.s_axi_arready), 64'd1);
  endtask

  initial begin
    bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wlast = 1'b0;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

    #2 reset = 1'b1;
    tick(); tick();
    check("rst_arready", 64'(bus.s_axi_arready), 64'd1);
    check("rst_awready", 64'(bus.s_axi_awready), 64'd0);
    check("rst_wready",  64'(bus.s_axi_wready),  64'd0);
    check("rst_bvalid",  64'(bus.s_axi_bvalid),  64'd0);
    check("rst_rvalid",  64'(bus.s_axi_rvalid),  64'd0);
    check("rst_rlast",   64'(bus.s_axi_rlast),   64'd0);
    check("rst_rresp",   64'(bus.s_axi_rresp),   64'd0);
    check("rst_bresp",   64'(bus.s_axi_bresp),   64'd0);
    check("rst_rdata",   bus.s_axi_rdata,        64'd0);
    reset = 1'b0;
    tick();

    // Preload words 0x40..0x47 with their own index.
    axi_write("pre", 64'h200, 8'd7, 2'b01, 64'h40, 7, resp);
    check("pre_bresp", 64'(resp), 64'd0);

    for (int i = 0; i < 8; i++) exp_w[i] = 64'h40 + 64'((i + 3) % 8);
    axi_read("wrap", 64'h218, 8'd7, 2'b10, 1'b0);
    axi_read("wrap_stall", 64'h218, 8'd7, 2'b10, 1'b1);

    axi_write("wwrap", 64'h100, 8'd7, 2'b10, 64'hA0, 7, resp);
    check("wwrap_bresp", 64'(resp), 64'd0);
    for (int i = 0; i < 8; i++) exp_w[i] = 64'hA0 + 64'(i);
    axi_read("incr", 64'h100, 8'd7, 2'b01, 1'b0);

    // Early wlast: still four beats, SLVERR; then a clean write is OKAY again.
    axi_write("early", 64'h300, 8'd3, 2'b01, 64'hB0, 1, resp);
    check("early_bresp", 64'(resp), 64'd2);
    axi_write("clean", 64'h340, 8'd1, 2'b01, 64'hC0, 1, resp);
    check("clean_bresp", 64'(resp), 64'd0);
    for (int i = 0; i < 4; i++) exp_w[i] = 64'hB0 + 64'(i);
    axi_read("early_rb", 64'h300, 8'd3, 2'b01, 1'b0);

    // Simultaneous AR and AW: read goes first.
    bus.s_axi_awaddr  = 64'h400;
    bus.s_axi_awlen   = 8'd0;
    bus.s_axi_awsize  = 3'd3;
    bus.s_axi_awburst = 2'b01;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_arvalid = 1'b1;
    #1;
    check("both_awready", 64'(bus.s_axi_awready), 64'd0);
    check("both_arready", 64'(bus.s_axi_arready), 64'd1);
    exp_w[0] = 64'h40;
    exp_w[1] = 64'h41;
    chk_aw_blocked = 1'b1;
    axi_read("both_rd", 64'h200, 8'd1, 2'b01, 1'b0);
    chk_aw_blocked = 1'b0;
    check("both_awready_after", 64'(bus.s_axi_awready), 64'd1);
    axi_write("both_wr", 64'h400, 8'd0, 2'b01, 64'hD0, 0, resp);
    check("both_bresp", 64'(resp), 64'd0);
    exp_w[0] = 64'hD0;
    axi_read("both_rb", 64'h400, 8'd0, 2'b01, 1'b0);

    // Reset while the third beat of a read is presented.
    bus.s_axi_araddr  = 64'h200;
    bus.s_axi_arlen   = 8'd7;
    bus.s_axi_arsize  = 3'd3;
    bus.s_axi_arburst = 2'b01;
    bus.s_axi_arvalid = 1'b1;
    tick();
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;
    tick();
    tick();
    #1;
    check("mid_beat3_data", bus.s_axi_rdata, 64'h42);
    reset = 1'b1;
    #1;
    check("mid_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
    check("mid_rlast",  64'(bus.s_axi_rlast),  64'd0);
    check("mid_arready", 64'(bus.s_axi_arready), 64'd1);
    bus.s_axi_rready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_arready", 64'(bus.s_axi_arready), 64'd1);
    for (int i = 0; i < 8; i++) exp_w[i] = 64'h40 + 64'(i);
    axi_read("post_rd", 64'h200, 8'd7, 2'b01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_burst_responder.md
Name: axi_burst_responder

Overview:
- AXI4 subordinate (responder) that serves the cache-side bus master's 8-beat WRAP line fills and write-backs from an internal word-addressed memory.
- Used as the memory endpoint in block-level and system simulation, and as on-chip scratch memory.
- One outstanding transaction at a time; reads and writes share a single FSM.

Parameters:
- DATA_WIDTH, 64, bytes per beat = DATA_WIDTH/8.
- ADDR_WIDTH, 64, AXI address width.
- MEM_WORDS_LOG, 12, log2 of the number of DATA_WIDTH words in memory.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- s_axi_awaddr  in  ADDR_WIDTH  write burst start address.
- s_axi_awlen  in  8  beats-1.
- s_axi_awsize  in  3  log2 bytes per beat.
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- s_axi_awvalid/s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid/s_axi_wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid/s_axi_bready  out/in  1  B handshake.
- s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  ADDR_WIDTH/8/3/2  read burst, same encodings as AW.
- s_axi_arvalid/s_axi_arready  in/out  1  AR handshake.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid/s_axi_rready  out/in  1  R handshake.
- Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- FSM states: IDLE, RD, WR, WRESP.
- Reset values: FSM in IDLE; arready=1, awready=0 (awready is combinational), wready=0, bvalid=0, rvalid=0, rlast=0, rresp=bresp=00, rdata=0. Memory contents are not cleared.
- IDLE outputs: arready=1; awready=!arvalid. Reads win on a simultaneous AR and AW.
- AR handshake:
  - Latch addr, len, size and burst; clear beat counter; go to RD.
  - The memory is read synchronously, so rvalid rises the cycle after the handshake (1-cycle latency).
- RD:
  - rvalid=1; rdata = mem[beat address].
  - rlast=1 when beat==len.
  - On rvalid&&rready: increment beat and present the next word on the next cycle with no bubble.
  - On the last-beat handshake, return to IDLE; arready is 1 in that next cycle.
  - rvalid must stay high and rdata stable while rready=0.
- AW handshake: latch the burst fields and go to WR.
- WR:
  - wready=1.
  - Each wvalid&&wready writes wdata to mem[beat address] and increments beat.
  - The burst ends on the beat where beat==len, regardless of wlast; then go to WRESP.
  - If wlast differs from (beat==len) on any beat, set a sticky error flag.
- WRESP: bvalid=1; bresp=10 (SLVERR) if the flag is set, otherwise 00. On bready, clear the flag and go to IDLE.
- Beat address, with bytes = 1<<size and word index = byte address >> log2(DATA_WIDTH/8), low MEM_WORDS_LOG bits:
  - FIXED: start address.
  - INCR: start + beat*bytes.
  - WRAP: mask = (len+1)*bytes-1; address = (start & ~mask) | ((start + beat*bytes) & mask).
- WRAP is legal only for len in {1,3,7,15}; any other len is treated as INCR.
- Arithmetic is ADDR_WIDTH wide; carries out of the top bit are discarded.
- Addresses at or beyond the memory size alias (modulo) into the memory.
- Async reset mid-burst: all handshake outputs drop immediately; any partially written burst stays in memory.

Optional Feature:
- Macro: AXI_RESP_DECERR_EN.
- Defined: any beat whose byte address has set bits above MEM_WORDS_LOG+log2(DATA_WIDTH/8) behaves as follows:
  - Reads return rdata=0 with rresp=11 (DECERR).
  - Writes are dropped and bresp=11. DECERR takes priority over SLVERR.
- Undefined: addresses alias, rresp is always 00, and the upper-bit check logic is absent.

Decomposition:
- Package axi_pkg holds:
  - burst_e {FIXED, INCR, WRAP}
  - resp codes OKAY/SLVERR/DECERR
  - resp_state_e {IDLE, RD, WR, WRESP}
  - localparam BYTES_LOG
- Sub-module axi_beat_addr: combinational beat-address generator (start, len, size, burst, beat -> address), shared with the master side for checking.

Test Plan:
- Preload mem words 0x40..0x47 with i; AR araddr=0x218 (word 0x43), len=7, size=3, WRAP -> rdata 0x43,0x44,...,0x47,0x40,0x41,0x42 on consecutive cycles; rlast on the 8th beat; rresp=00.
- Same read with rready toggling 1,0,0,1 -> no beat lost or repeated; rdata stable while stalled.
- AW 0x100, len=7, WRAP, wdata=0xA0..0xA7, wlast on beat 8 -> bresp=00; a following INCR read of 0x100 returns 0xA0..0xA7.
- Write len=3 with wlast on beat 2 -> 4 beats still accepted, bresp=10; the next clean write returns bresp=00.
- arvalid and awvalid raised in the same cycle -> read served first; awready=0 until the read completes, then AW accepted.
- Assert reset during beat 3 of a read -> rvalid=0 asynchronously; after release arready=1 and a new read completes normally.
